// File: rtl/aes_pkg.sv
// AES helpers shared by the encryptor and decryptor: S-boxes, GF(2^8) arithmetic,
// and whole-state ShiftRows / MixColumns transforms.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [15:0][7:0] bytes_t;

  // Byte 0x00 sits in the most significant byte of each table.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i[2:0]]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic state_t sub_bytes(input state_t s);
    bytes_t b;
    bytes_t o;
    b = s;
    o = '0;
    for (int unsigned i = 0; i < 16; i++) o[i[3:0]] = sbox(b[i[3:0]]);
    return o;
  endfunction

  // Column-major bytes 0..15; row r of each column takes the byte r columns to its right.
  function automatic state_t shift_rows(input state_t s);
    return {s[127:120], s[87:80],   s[47:40],   s[7:0],
            s[95:88],   s[55:48],   s[15:8],    s[103:96],
            s[63:56],   s[23:16],   s[111:104], s[71:64],
            s[31:24],   s[119:112], s[79:72],   s[39:32]};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic state_t mix_columns(input state_t s);
    return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
  endfunction

endpackage

// File: rtl/aes_encrypt_round.sv
// One combinational AES encryption round; the final round skips MixColumns.
module aes_round
  import aes_pkg::*;
(
  input  state_t state_i,
  input  state_t rkey_i,
  input  logic   final_i,
  output state_t state_o
);

  state_t shifted;

  // SubBytes -> ShiftRows -> (MixColumns unless final) -> AddRoundKey
  always_comb begin
    shifted = shift_rows(sub_bytes(state_i));
    state_o = (final_i ? shifted : mix_columns(shifted)) ^ rkey_i;
  end

endmodule

// File: rtl/aes_encrypt.sv
// Iterative AES encryptor: loads in^K0, then one round per enabled clock until done.
module aes_encrypt
  import aes_pkg::*;
#(
  parameter int unsigned NK = 4,
  parameter int unsigned NR = NK + 6
) (
  input  logic [127:0]          in,
  input  logic [128*(NR+1)-1:0] key_sched,
  output logic [127:0]          out,
  input  logic                  clk,
  input  logic                  enable,
  input  logic                  reset,
  output logic                  done
);

  localparam logic [3:0] LAST = 4'(NR);

  logic [NR:0][127:0] keys;
  logic [3:0]         kidx;
  state_t             rkey;
  state_t             round_out;
  state_t             state_q, state_d;
  logic [3:0]         rnd_q, rnd_d;
  logic               done_q, done_d;

  assign keys = key_sched;
  assign out  = state_q;
  assign done = done_q;

  // Round key for the current round; K0 lives in the top slice, i.e. keys[NR].
  always_comb begin
    kidx = (rnd_q > LAST) ? '0 : LAST - rnd_q;
    rkey = keys[kidx];
  end

  aes_round u_round (
    .state_i (state_q),
    .rkey_i  (rkey),
    .final_i (rnd_q == LAST),
    .state_o (round_out)
  );

  // Round sequencing: load, NR rounds, then hold the ciphertext.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    done_d  = done_q;
    if (enable) begin
      if (rnd_q == '0) begin
        state_d = in ^ rkey;
        rnd_d   = 4'd1;
      end else if (rnd_q <= LAST) begin
        state_d = round_out;
        rnd_d   = rnd_q + 4'd1;
        if (rnd_q == LAST) done_d = 1'b1;
      end
    end
  end

  // State, round counter and done flag; reset aborts at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '0;
      rnd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_aes_encrypt.sv
// Directed bench for aes_encrypt against FIPS-197 vectors for all three key sizes.
module tb_aes_encrypt;
  import aes_pkg::*;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] R1     = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] R2     = 128'h89d810e8855ace682d1843d8cb128fe4;
  localparam logic [127:0] R4     = 128'hfa636a2825b339c940668a3157244d17;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset  = 1'b0;
  logic          enable = 1'b0;
  logic [127:0]  pt     = PT;
  logic [1919:0] ks128  = '0;
  logic [1919:0] ks192  = '0;
  logic [1919:0] ks256  = '0;
  logic [127:0]  out128, out192, out256;
  logic          done128, done192, done256;

  int n_checks = 0;
  int n_errors = 0;

  aes_encrypt #(.NK(4), .NR(10)) dut128 (
    .in(pt), .key_sched(ks128[1919 -: 1408]), .out(out128),
    .clk(clk), .enable(enable), .reset(reset), .done(done128));

  aes_encrypt #(.NK(6), .NR(12)) dut192 (
    .in(pt), .key_sched(ks192[1919 -: 1664]), .out(out192),
    .clk(clk), .enable(enable), .reset(reset), .done(done192));

  aes_encrypt #(.NK(8), .NR(14)) dut256 (
    .in(pt), .key_sched(ks256), .out(out256),
    .clk(clk), .enable(enable), .reset(reset), .done(done256));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // FIPS-197 key expansion; round key 0 ends up in the top 128 bits.
  function automatic logic [1919:0] expand_key(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] ks;
    int            nw;
    nw = 4 * (nk + 7);
    rc = 8'h01;
    ks = '0;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < nw; i++) ks[1919 - 32*i -: 32] = w[i];
    return ks;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must clear without a clock.
  task automatic pulse_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    check({tag, "_rst_out"}, out128, '0);
    check({tag, "_rst_done"}, {127'b0, done128}, '0);
    #1 reset = 1'b0;
  endtask

  initial begin
    ks128 = expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    ks192 = expand_key({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    ks256 = expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

    // Reset state
    #2 reset = 1'b1;
    tick();
    check("reset_out128", out128, '0);
    check("reset_out256", out256, '0);
    check("reset_done192", {127'b0, done192}, '0);
    reset  = 1'b0;
    enable = 1'b1;

    // Tests 1-3: all key sizes side by side
    for (int e = 1; e <= 20; e++) begin
      tick();
      case (e)
        1:  begin check("t1_e1_out", out128, R1); check("t1_e1_done", {127'b0, done128}, '0); end
        2:  check("t1_e2_out", out128, R2);
        10: check("t1_e10_done", {127'b0, done128}, '0);
        11: begin check("t1_ct", out128, CT128); check("t1_done", {127'b0, done128}, 128'd1); end
        12: check("t2_e12_done", {127'b0, done192}, '0);
        13: begin check("t2_ct", out192, CT192); check("t2_done", {127'b0, done192}, 128'd1); end
        14: check("t3_e14_done", {127'b0, done256}, '0);
        default: ;
      endcase
      if (e >= 15) begin
        check("t3_ct", out256, CT256);
        check("t3_done", {127'b0, done256}, 128'd1);
      end
    end
    check("t1_hold_ct", out128, CT128);

    // Test 5: reset with done high, then a mid-run abort and a full rerun
    pulse_reset("t5a");
    for (int e = 1; e <= 5; e++) tick();
    pulse_reset("t5b");
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (e == 10) check("t5_e10_done", {127'b0, done128}, '0);
    end
    check("t5_ct", out128, CT128);
    check("t5_done", {127'b0, done128}, 128'd1);

    // Test 4: three-cycle stall after edge 4
    pulse_reset("t4");
    for (int e = 1; e <= 4; e++) tick();
    check("t4_e4_out", out128, R4);
    enable = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("t4_stall_out", out128, R4);
      check("t4_stall_done", {127'b0, done128}, '0);
    end
    enable = 1'b1;
    for (int e = 5; e <= 10; e++) tick();
    check("t4_e10_done", {127'b0, done128}, '0);
    tick();
    check("t4_ct", out128, CT128);
    check("t4_done", {127'b0, done128}, 128'd1);

    // Test 6: plaintext changes after the load edge are ignored
    pulse_reset("t6");
    tick();
    check("t6_e1_out", out128, R1);
    pt = ~PT;
    for (int e = 2; e <= 11; e++) tick();
    check("t6_ct", out128, CT128);
    check("t6_done", {127'b0, done128}, 128'd1);
    pt = PT;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
